flat_resp_capture: RTL
======================

// Module: flat_resp_capture
// PURPOSE
//  Receive-side counterpart of the flat-vector stimulus driver: samples the DUT's wide
//  out_flat response each enabled cycle, stamps it with a cycle number, buffers frames in a
//  small FIFO and streams them out as CHUNK_W-bit beats over valid/ready. Sits between the
//  fuzzed `top` and the trace/compare sink, replacing free-running $write dumps with a
//  synthesizable, back-pressured response channel.
// PARAMETERS
//  IN_W     159  width of sampled response vector (in_flat)
//  CHUNK_W  32   output beat width; NCHUNK = ceil(IN_W/CHUNK_W) (=5 at defaults)
//  DEPTH    4    frame FIFO depth (power of 2, >=2)
//  CNT_W    32   cycle-stamp / drop-counter width
// PORTS
//  clk          in   1        clock, all state on rising edge
//  rst          in   1        asynchronous, active-high reset
//  cap_en       in   1        sample in_flat at this edge
//  in_flat      in   IN_W     DUT response vector
//  out_valid    out  1        beat available
//  out_ready    in   1        sink accepts beat
//  out_data     out  CHUNK_W  current beat
//  out_last     out  1        beat is final chunk of frame
//  out_stamp    out  CNT_W    cycle stamp of frame being sent
//  fifo_level   out  $clog2(DEPTH)+1  frames buffered
//  drop_cnt     out  CNT_W    frames lost to full FIFO, saturating
//  overflow     out  1        sticky: any frame dropped since reset
//  sig          out  32       MISR signature (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0; cycle counter 0; FIFO empty; FSM IDLE. Async assert mid-frame
//    discards partial frame and buffered frames; out_valid drops immediately.
//  - Cycle counter: +1 every clk edge after reset release, wraps modulo 2^CNT_W; first edge
//    after release stamps 0.
//  - Capture: cap_en=1 at edge -> push {stamp, in_flat}. If FIFO full and no pop this edge:
//    frame dropped, drop_cnt+1 (saturates at all-ones), overflow<=1. Full + pop same edge:
//    push accepted, level unchanged.
//  - Chunking: frame zero-extended to NCHUNK*CHUNK_W bits; chunk 0 = most significant
//    (matches MSB-first trace text order); at defaults chunk0 = {1'b0, in_flat[158:128]},
//    chunk4 = in_flat[31:0].
//  - FSM IDLE: FIFO non-empty -> pop head into shift reg, idx<=0, go SEND (out_valid=1
//    after that edge). Capture-to-first-beat latency = 2 edges from empty/IDLE.
//  - FSM SEND: out_valid=1; out_data/out_last/out_stamp stable while !out_ready.
//    valid&&ready: idx<NCHUNK-1 -> idx+1, next chunk; idx==NCHUNK-1 (out_last=1) -> IDLE.
//    One idle bubble between frames (out_valid=0 for exactly one cycle).
//  - out_ready is ignored while out_valid=0; no combinational path in->out_valid.
//  - fifo_level updates on the edge of push/pop; range 0..DEPTH.
// CONFIGURATION
//  FLAT_MISR_EN defined: on every cap_en edge (accepted or dropped),
//    sig <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ F, F = XOR of all 32-bit slices of
//    in_flat zero-extended to a multiple of 32; reset value 32'h0. Compact pass/fail check
//    across runs with equal seed.
//  FLAT_MISR_EN undefined: no MISR logic; sig tied 32'h0.
// TESTING
//  1. Reset release, cap_en=1 one cycle, in_flat=159'h1, ready=1 -> 5 beats: 4x 0 then
//     32'h1 with out_last=1, out_stamp=0; valid 2 edges after capture.
//  2. in_flat all-ones, ready=1 -> chunk0=32'h7FFF_FFFF, chunks1-4=32'hFFFF_FFFF.
//  3. ready=0, cap_en=1 for 10 cycles, DEPTH=4 -> 1 frame in shift reg, level=4,
//     drop_cnt=5, overflow=1; release ready -> 5 frames out, stamps 0,1,2,3,4.
//  4. ready toggled 1/0 each cycle mid-frame -> out_data never changes while !ready; each
//     frame exactly 5 beats, 1-cycle bubble between frames.
//  5. rst pulsed while sending beat 2 -> out_valid=0 same cycle, level=0, drop_cnt=0,
//     next capture stamp restarts at 0.
//  6. FLAT_MISR_EN, one capture of in_flat=159'h1 from reset -> sig=32'h1; undefined -> 0.

Source files
------------

// File: rtl/flat_resp_capture.sv
// Response capture: stamps in_flat frames, buffers them in a FIFO, streams CHUNK_W-bit beats MSB-first.
// Optional MISR signature on sig when FLAT_MISR_EN is defined; otherwise sig is tied to zero.
module flat_resp_capture #(
    parameter int IN_W    = 159,
    parameter int CHUNK_W = 32,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cap_en,
    input  logic [IN_W-1:0]          in_flat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHUNK_W-1:0]       out_data,
    output logic                     out_last,
    output logic [CNT_W-1:0]         out_stamp,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     overflow,
    output logic [31:0]              sig
);

    localparam int NCHUNK  = (IN_W + CHUNK_W - 1) / CHUNK_W;
    localparam int FRAME_W = NCHUNK * CHUNK_W;
    localparam int AW      = $clog2(DEPTH);
    localparam int IW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [IN_W-1:0]      mem_data  [DEPTH];
    logic [CNT_W-1:0]     mem_stamp [DEPTH];
    logic [AW:0]          wr_q, rd_q;
    logic [FRAME_W-1:0]   sreg_q, sreg_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]     stamp_q, stamp_d;
    logic [CNT_W-1:0]     drop_q;
    logic                 ovf_q;
    logic                 empty, full, pop, push, drop;

    assign fifo_level = wr_q - rd_q;
    assign empty      = (wr_q == rd_q);
    assign full       = (fifo_level == (AW+1)'(DEPTH));
    // A pop on the same edge frees the head slot, so a full FIFO can still take the push.
    assign push       = cap_en && (!full || pop);
    assign drop       = cap_en && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != '1) drop_q <= drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_q[AW-1:0]]  <= in_flat;
            mem_stamp[wr_q[AW-1:0]] <= cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            idx_q   <= '0;
            stamp_q <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
            stamp_q <= stamp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        idx_d   = idx_q;
        stamp_d = stamp_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sreg_d  = FRAME_W'(mem_data[rd_q[AW-1:0]]);
                    stamp_d = mem_stamp[rd_q[AW-1:0]];
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == IW'(NCHUNK - 1)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        sreg_d = sreg_q << CHUNK_W;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = (state_q == SEND);
    assign out_data  = sreg_q[FRAME_W-1 -: CHUNK_W];
    assign out_last  = out_valid && (idx_q == IW'(NCHUNK - 1));
    assign out_stamp = stamp_q;
    assign drop_cnt  = drop_q;
    assign overflow  = ovf_q;

`ifdef FLAT_MISR_EN
    localparam int NSL   = (IN_W + 31) / 32;
    localparam int EXT_W = NSL * 32;

    logic [31:0]      sig_q, fold;
    logic [EXT_W-1:0] in_ext;

    always_comb begin
        in_ext = EXT_W'(in_flat);
        fold   = '0;
        for (int unsigned i = 0; i < NSL; i++) fold ^= in_ext[i*32 +: 32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         sig_q <= '0;
        else if (cap_en) sig_q <= {sig_q[30:0], sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0]} ^ fold;
    end

    assign sig = sig_q;
`else
    assign sig = '0;
`endif

endmodule
